// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes,
// FSM state encoding and small bit-level helper functions.
package uart_pkg;

  // Parity modes
  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  // Receiver FSM state encoding
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  // Parity bit a transmitter sends for 'data' (up to 9 bits, zero-extended).
  function automatic logic parity_calc(input logic [8:0] data, input logic [1:0] mode);
    logic p;
    case (mode)
      PARITY_ODD:  p = ~(^data);
      PARITY_EVEN: p = ^data;
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
// RST_VAL sets the value both flops take in reset (1 for an idle UART line).
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture of the asynchronous input into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (DATA_BITS 5..9, none/odd/even parity, 1 or 2
// stop bits) with a single-entry valid/ready holding register.
// Optional feature macro: UART_RX_MAJORITY_EN -- three samples per bit
// (mid-1, mid, mid+1) with a 2-of-3 vote, decision taken at mid+1.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  // Vote completes one cycle after the nominal mid point.
  localparam logic [CNT_W-1:0] START_PT  = CNT_W'(CLKS_PER_BIT / 2);
`else
  localparam logic [CNT_W-1:0] START_PT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
`endif
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [1:0]       PMODE     = 2'(PARITY_MODE);

  logic                 sync_s;
  logic                 prev_r;
  logic                 fall_s;
  logic                 bit_s;
  logic                 wrap_s;
  logic [2:0]           state_r;
  logic [2:0]           state_nx_s;
  logic [CNT_W-1:0]     clk_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 perr_r;
  logic                 fe_cand_r;
  logic                 done_s;
  logic                 fe_final_s;
  logic                 hold_full_s;

  uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rx_pin),
    .q   (sync_s)
  );

  // Edge register: previous synchronised line value for falling-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_r <= 1'b1;
    end else begin
      prev_r <= sync_s;
    end
  end

  assign fall_s = ~sync_s & prev_r;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_r;

  // Two-deep history of the synced line: hist_r[1] = mid-1, hist_r[0] = mid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r <= 2'b11;
    end else begin
      hist_r <= {hist_r[0], sync_s};
    end
  end

  assign bit_s = maj3(hist_r[1], hist_r[0], sync_s);
`else
  assign bit_s = sync_s;
`endif

  assign wrap_s      = (clk_cnt_r == CNT_MAX);
  assign hold_full_s = rx_valid & ~rx_ready;

  // Next-state decode and frame-completion detect
  always_comb begin
    state_nx_s = state_r;
    done_s     = 1'b0;
    fe_final_s = fe_cand_r | ~bit_s;
    case (state_r)
      IDLE: begin
        if (fall_s) state_nx_s = START;
        else        state_nx_s = IDLE;
      end
      START: begin
        if (clk_cnt_r == START_PT) state_nx_s = bit_s ? IDLE : DATA;
        else                       state_nx_s = START;
      end
      DATA: begin
        if (wrap_s && (bit_cnt_r == DATA_LAST)) state_nx_s = (PARITY_MODE != 0) ? PARITY : STOP;
        else                                    state_nx_s = DATA;
      end
      PARITY: begin
        if (wrap_s) state_nx_s = STOP;
        else        state_nx_s = PARITY;
      end
      STOP: begin
        if (wrap_s && (bit_cnt_r == STOP_LAST)) begin
          done_s     = 1'b1;
          state_nx_s = fe_final_s ? WAIT_HIGH : IDLE;
        end else begin
          state_nx_s = STOP;
        end
      end
      WAIT_HIGH: begin
        if (sync_s) state_nx_s = IDLE;
        else        state_nx_s = WAIT_HIGH;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM state, bit timing counters, shift register and error candidates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      clk_cnt_r <= '0;
      bit_cnt_r <= '0;
      shift_r   <= '0;
      perr_r    <= 1'b0;
      fe_cand_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      case (state_r)
        IDLE: begin
          clk_cnt_r <= '0;
          bit_cnt_r <= '0;
          perr_r    <= 1'b0;
          fe_cand_r <= 1'b0;
        end
        START: begin
          clk_cnt_r <= (clk_cnt_r == START_PT) ? '0 : clk_cnt_r + CNT_W'(1);
        end
        DATA: begin
          clk_cnt_r <= wrap_s ? '0 : clk_cnt_r + CNT_W'(1);
          if (wrap_s) begin
            shift_r   <= {bit_s, shift_r[DATA_BITS-1:1]};
            bit_cnt_r <= (bit_cnt_r == DATA_LAST) ? '0 : bit_cnt_r + BIT_W'(1);
          end
        end
        PARITY: begin
          clk_cnt_r <= wrap_s ? '0 : clk_cnt_r + CNT_W'(1);
          if (wrap_s) perr_r <= (bit_s != parity_calc(9'(shift_r), PMODE));
        end
        STOP: begin
          clk_cnt_r <= wrap_s ? '0 : clk_cnt_r + CNT_W'(1);
          if (wrap_s) begin
            fe_cand_r <= fe_final_s;
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
          end
        end
        default: begin
          clk_cnt_r <= '0;
          bit_cnt_r <= '0;
        end
      endcase
    end
  end

  // Holding register, valid/ready handshake, overrun pulse and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      overrun <= done_s & hold_full_s;
      busy    <= (state_nx_s != IDLE);
      if (done_s && !hold_full_s) begin
        rx_data    <= shift_r;
        parity_err <= perr_r;
        frame_err  <= fe_final_s;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
      end else begin
        rx_valid   <= rx_valid;
      end
    end
  end

endmodule
